// File: rtl/button_debouncer.sv
// rtl/button_debouncer.sv - push-button synchroniser, debouncer, press/release strobes and sticky press flag
module button_debouncer #(
    parameter int WIDTH           = 1,
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter bit ACTIVE_LOW      = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] btn_raw,
    output logic [WIDTH-1:0] btn_level,
    output logic [WIDTH-1:0] btn_press,
    output logic [WIDTH-1:0] btn_release,
    input  logic [WIDTH-1:0] evt_clear,
    output logic [WIDTH-1:0] evt_pending
);

    localparam int             CW       = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0]  CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [WIDTH-1:0] w_norm;
    logic [WIDTH-1:0] w_flip;
    logic [WIDTH-1:0] r_s1;
    logic [WIDTH-1:0] r_s2;
    logic [WIDTH-1:0] r_level;
    logic [WIDTH-1:0] r_press;
    logic [WIDTH-1:0] r_release;
    logic [WIDTH-1:0] r_pending;
    logic [CW-1:0]    r_cnt [WIDTH];

    // Normalise to 1 = pressed so the synchroniser resets to "released".
    assign w_norm = ACTIVE_LOW ? ~btn_raw : btn_raw;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_s1 <= '0;
            r_s2 <= '0;
        end else begin
            r_s1 <= w_norm;
            r_s2 <= r_s1;
        end
    end

    always_comb begin
        w_flip = '0;
        for (int i = 0; i < WIDTH; i++) begin
            w_flip[i] = (r_s2[i] != r_level[i]) && (r_cnt[i] == CNT_LAST);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_level   <= '0;
            r_press   <= '0;
            r_release <= '0;
            r_pending <= '0;
            for (int i = 0; i < WIDTH; i++) begin
                r_cnt[i] <= '0;
            end
        end else begin
            // A matching sample restarts the run, so any bounce shorter than the window is discarded.
            for (int i = 0; i < WIDTH; i++) begin
                if ((r_s2[i] == r_level[i]) || w_flip[i]) begin
                    r_cnt[i] <= '0;
                end else begin
                    r_cnt[i] <= r_cnt[i] + CW'(1);
                end
            end
            r_level   <= r_level ^ w_flip;
            r_press   <= w_flip & r_s2;
            r_release <= w_flip & ~r_s2;
            // Set has priority over clear so a press coinciding with a clear is never lost.
            r_pending <= (w_flip & r_s2) | (r_pending & ~evt_clear);
        end
    end

    assign btn_level   = r_level;
    assign btn_press   = r_press;
    assign btn_release = r_release;
    assign evt_pending = r_pending;

endmodule

// File: tb/tb_button_debouncer.sv
// tb/tb_button_debouncer.sv - self-checking bench for button_debouncer
module tb_button_debouncer;

    localparam int DC = 4;

    logic       clk = 1'b0;
    logic       rst_a, rst_b;
    logic [0:0] raw_a, clr_a, lvl_a, prs_a, rel_a, pnd_a;
    logic [3:0] raw_b, clr_b, lvl_b, prs_b, rel_b, pnd_b;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    button_debouncer #(.WIDTH(1), .DEBOUNCE_CYCLES(DC), .ACTIVE_LOW(1)) dut_a (
        .clk(clk), .reset(rst_a), .btn_raw(raw_a), .btn_level(lvl_a),
        .btn_press(prs_a), .btn_release(rel_a), .evt_clear(clr_a), .evt_pending(pnd_a)
    );

    button_debouncer #(.WIDTH(4), .DEBOUNCE_CYCLES(DC), .ACTIVE_LOW(0)) dut_b (
        .clk(clk), .reset(rst_b), .btn_raw(raw_b), .btn_level(lvl_b),
        .btn_press(prs_b), .btn_release(rel_b), .evt_clear(clr_b), .evt_pending(pnd_b)
    );

    // Reference: channel 0 is dut_a bit 0, channels 1..4 are dut_b bits 0..3.
    // The level flips when the last DC synchronised samples (pin value two edges
    // earlier) all disagree with it and no reset or flip happened inside that window.
    int t = 100;
    bit m_level [5];
    bit m_press [5];
    bit m_rel   [5];
    bit m_pend  [5];
    int last_evt [5];
    bit rec [5][16];

    always @(posedge clk) begin
        bit rst, nval, clr, flip;
        t = t + 1;
        for (int ch = 0; ch < 5; ch++) begin
            if (ch == 0) begin
                rst = rst_a; nval = ~raw_a[0]; clr = clr_a[0];
            end else begin
                rst = rst_b; nval = raw_b[ch-1]; clr = clr_b[ch-1];
            end
            if (rst) begin
                m_level[ch] = 0; m_press[ch] = 0; m_rel[ch] = 0; m_pend[ch] = 0;
                last_evt[ch] = t;
                rec[ch][t % 16] = 0;
                rec[ch][(t - 1) % 16] = 0;
            end else begin
                flip = (t - last_evt[ch] >= DC);
                for (int j = 0; j < DC; j++) begin
                    if (rec[ch][(t - j - 2) % 16] == m_level[ch]) flip = 0;
                end
                m_press[ch] = flip && !m_level[ch];
                m_rel[ch]   = flip && m_level[ch];
                if (flip) begin
                    m_level[ch] = !m_level[ch];
                    last_evt[ch] = t;
                end
                m_pend[ch] = m_press[ch] | (m_pend[ch] & !clr);
                rec[ch][t % 16] = nval;
            end
        end
    end

    task test_reset;
        rst_a = 1; rst_b = 1; raw_a = 1; raw_b = 0; clr_a = 0; clr_b = 0;
        repeat (3) @(negedge clk);
        checks++;
        if ({lvl_a, prs_a, rel_a, pnd_a} !== 4'b0000) begin
            errors++; $display("FAIL reset_a got %b required 0000", {lvl_a, prs_a, rel_a, pnd_a});
        end
        checks++;
        if ({lvl_b, prs_b, rel_b, pnd_b} !== 16'h0000) begin
            errors++; $display("FAIL reset_b got %h required 0000", {lvl_b, prs_b, rel_b, pnd_b});
        end
        rst_a = 0; rst_b = 0;
        repeat (3) @(negedge clk);
        checks++;
        if ({lvl_a, prs_a, rel_a, pnd_a} !== 4'b0000) begin
            errors++; $display("FAIL idle_a got %b required 0000", {lvl_a, prs_a, rel_a, pnd_a});
        end
    endtask

    task test_press;
        @(negedge clk);
        raw_a = 0;
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            if (i == 5) begin
                checks++;
                if (lvl_a !== 1'b0 || prs_a !== 1'b0) begin
                    errors++; $display("FAIL press_early lvl %b prs %b required 0 0", lvl_a, prs_a);
                end
            end
            if (i == 6) begin
                checks++;
                if (lvl_a !== 1'b1 || prs_a !== 1'b1 || rel_a !== 1'b0) begin
                    errors++; $display("FAIL press_edge lvl %b prs %b rel %b required 1 1 0", lvl_a, prs_a, rel_a);
                end
            end
            if (i >= 7) begin
                checks++;
                if (prs_a !== 1'b0 || pnd_a !== 1'b1 || lvl_a !== 1'b1) begin
                    errors++; $display("FAIL press_after prs %b pnd %b lvl %b required 0 1 1", prs_a, pnd_a, lvl_a);
                end
            end
        end
    endtask

    task test_bounce;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            checks++;
            if (lvl_a !== 1'b1 || rel_a !== 1'b0) begin
                errors++; $display("FAIL bounce_hold i %0d lvl %b rel %b required 1 0", i, lvl_a, rel_a);
            end
            raw_a = (i % 2 == 0) ? 1'b1 : 1'b0;
        end
        @(negedge clk);
        raw_a = 1;
        for (int i = 1; i <= 7; i++) begin
            @(negedge clk);
            if (i == 5) begin
                checks++;
                if (lvl_a !== 1'b1 || rel_a !== 1'b0) begin
                    errors++; $display("FAIL release_early lvl %b rel %b required 1 0", lvl_a, rel_a);
                end
            end
            if (i == 6) begin
                checks++;
                if (lvl_a !== 1'b0 || rel_a !== 1'b1 || prs_a !== 1'b0) begin
                    errors++; $display("FAIL release_edge lvl %b rel %b prs %b required 0 1 0", lvl_a, rel_a, prs_a);
                end
            end
            if (i == 7) begin
                checks++;
                if (rel_a !== 1'b0) begin
                    errors++; $display("FAIL release_width rel %b required 0", rel_a);
                end
            end
        end
    endtask

    task test_glitch;
        @(negedge clk);
        rst_a = 1;
        @(negedge clk);
        rst_a = 0; raw_a = 0;
        for (int i = 1; i <= 12; i++) begin
            @(negedge clk);
            if (i == 3) raw_a = 1;
            checks++;
            if ({lvl_a, prs_a, pnd_a} !== 3'b000) begin
                errors++; $display("FAIL glitch i %0d lvl/prs/pnd %b required 000", i, {lvl_a, prs_a, pnd_a});
            end
        end
    endtask

    task test_set_wins;
        @(negedge clk);
        raw_a = 0;
        for (int i = 1; i <= 9; i++) begin
            @(negedge clk);
            if (i == 5) clr_a = 1;
            if (i == 6) begin
                checks++;
                if (prs_a !== 1'b1 || pnd_a !== 1'b1) begin
                    errors++; $display("FAIL set_wins prs %b pnd %b required 1 1", prs_a, pnd_a);
                end
                clr_a = 0;
            end
            if (i == 7) begin
                checks++;
                if (pnd_a !== 1'b1) begin
                    errors++; $display("FAIL pend_kept pnd %b required 1", pnd_a);
                end
                clr_a = 1;
            end
            if (i == 8) begin
                checks++;
                if (pnd_a !== 1'b0) begin
                    errors++; $display("FAIL pend_clear pnd %b required 0", pnd_a);
                end
                clr_a = 0;
            end
        end
        @(negedge clk);
        raw_a = 1; clr_a = 1;
        repeat (8) @(negedge clk);
        raw_a = 0;
        for (int i = 1; i <= 7; i++) begin
            @(negedge clk);
            if (i == 6) begin
                checks++;
                if (prs_a !== 1'b1 || pnd_a !== 1'b1) begin
                    errors++; $display("FAIL clear_held_set prs %b pnd %b required 1 1", prs_a, pnd_a);
                end
            end
            if (i == 7) begin
                checks++;
                if (pnd_a !== 1'b0) begin
                    errors++; $display("FAIL clear_held_after pnd %b required 0", pnd_a);
                end
            end
        end
        clr_a = 0;
    endtask

    task test_multi;
        @(negedge clk);
        raw_b = 4'b1101;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            if (i == 2) raw_b[2] = 1'b0;
            checks++;
            if (lvl_b[2] !== 1'b0 || pnd_b[2] !== 1'b0) begin
                errors++; $display("FAIL multi_bit2 i %0d lvl %b pnd %b required 0 0", i, lvl_b[2], pnd_b[2]);
            end
            if (i == 5) begin
                checks++;
                if (lvl_b !== 4'b0000) begin
                    errors++; $display("FAIL multi_early lvl %b required 0000", lvl_b);
                end
            end
            if (i == 6) begin
                checks++;
                if (lvl_b !== 4'b1001 || prs_b !== 4'b1001) begin
                    errors++; $display("FAIL multi_edge lvl %b prs %b required 1001 1001", lvl_b, prs_b);
                end
            end
            if (i == 7) begin
                checks++;
                if (prs_b !== 4'b0000 || pnd_b !== 4'b1001) begin
                    errors++; $display("FAIL multi_after prs %b pnd %b required 0000 1001", prs_b, pnd_b);
                end
            end
        end
    endtask

    task test_reset_mid;
        @(negedge clk);
        rst_a = 1; raw_a = 1;
        @(negedge clk);
        rst_a = 0;
        repeat (3) @(negedge clk);
        raw_a = 0;
        for (int i = 1; i <= 12; i++) begin
            @(negedge clk);
            if (i == 4) rst_a = 1;
            if (i == 5) begin
                checks++;
                if ({lvl_a, prs_a, rel_a, pnd_a} !== 4'b0000) begin
                    errors++; $display("FAIL reset_mid got %b required 0000", {lvl_a, prs_a, rel_a, pnd_a});
                end
                rst_a = 0;
            end
            if (i == 10) begin
                checks++;
                if (lvl_a !== 1'b0 || prs_a !== 1'b0) begin
                    errors++; $display("FAIL held_early lvl %b prs %b required 0 0", lvl_a, prs_a);
                end
            end
            if (i == 11) begin
                checks++;
                if (lvl_a !== 1'b1 || prs_a !== 1'b1 || pnd_a !== 1'b1) begin
                    errors++; $display("FAIL held_press lvl %b prs %b pnd %b required 1 1 1", lvl_a, prs_a, pnd_a);
                end
            end
            if (i == 12) begin
                checks++;
                if (prs_a !== 1'b0) begin
                    errors++; $display("FAIL held_width prs %b required 0", prs_a);
                end
            end
        end
    endtask

    task test_random;
        int hold [5];
        logic [3:0] el, ep, er, en;
        for (int ch = 0; ch < 5; ch++) hold[ch] = 0;
        for (int c = 0; c < 800; c++) begin
            @(negedge clk);
            checks++;
            if ({lvl_a, prs_a, rel_a, pnd_a} !== {m_level[0], m_press[0], m_rel[0], m_pend[0]}) begin
                errors++;
                $display("FAIL rand_a cyc %0d got %b required %b", c, {lvl_a, prs_a, rel_a, pnd_a},
                         {m_level[0], m_press[0], m_rel[0], m_pend[0]});
            end
            for (int b = 0; b < 4; b++) begin
                el[b] = m_level[b+1]; ep[b] = m_press[b+1]; er[b] = m_rel[b+1]; en[b] = m_pend[b+1];
            end
            checks++;
            if ({lvl_b, prs_b, rel_b, pnd_b} !== {el, ep, er, en}) begin
                errors++;
                $display("FAIL rand_b cyc %0d got %h required %h", c, {lvl_b, prs_b, rel_b, pnd_b}, {el, ep, er, en});
            end
            checks++;
            if ((prs_b & rel_b) !== 4'b0000 || (prs_a & rel_a) !== 1'b0) begin
                errors++; $display("FAIL rand_excl cyc %0d prs %b rel %b required disjoint", c, prs_b, rel_b);
            end
            rst_a = ($urandom_range(0, 149) == 0);
            rst_b = ($urandom_range(0, 149) == 0);
            clr_a[0] = ($urandom_range(0, 7) == 0);
            clr_b = 4'($urandom_range(0, 15)) & 4'($urandom_range(0, 15)) & 4'($urandom_range(0, 15));
            for (int ch = 0; ch < 5; ch++) begin
                if (hold[ch] == 0) begin
                    hold[ch] = $urandom_range(1, 9);
                    if (ch == 0) raw_a[0] = 1'($urandom_range(0, 1));
                    else raw_b[ch-1] = 1'($urandom_range(0, 1));
                end else begin
                    hold[ch] = hold[ch] - 1;
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_press();
        test_bounce();
        test_glitch();
        test_set_wins();
        test_multi();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
